gen_clk_multi: RTL and testbench

//   NCH-channel programmable clock-enable/divided-clock generator; successor of the fixed /102 toggler.

---
 rtl/gen_clk_pkg.sv | 19 +
 rtl/gen_clk_chan.sv | 97 +++++++++
 rtl/gen_clk_multi.sv | 57 +++++
 tb/tb_gen_clk_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_clk_pkg.sv
// Shared types and defaults for the multi-channel clock generator.
package gen_clk_pkg;

    localparam int unsigned CTR_W_DEF    = 16;
    localparam int unsigned DEF_HALF_VAL = 50;

    typedef logic [CTR_W_DEF-1:0] ctr_t;

    typedef struct packed {
        ctr_t half;
        logic pend;
        ctr_t pend_half;
    } chan_cfg_t;

    function automatic logic ch_in_range(input int unsigned ch, input int unsigned nch);
        return ch < nch;
    endfunction

endpackage

// File: rtl/gen_clk_chan.sv
// One divider channel: counter, square-wave toggle, rising-edge tick and a pending half-period
// register that is only applied on a toggle boundary. Optional sync_i under GEN_CLK_SYNC_EN.
module gen_clk_chan
    import gen_clk_pkg::*;
#(
    parameter int unsigned CTR_W    = CTR_W_DEF,
    parameter int unsigned DEF_HALF = DEF_HALF_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             cfg_we_i,
    input  logic [CTR_W-1:0] cfg_half_i,
`ifdef GEN_CLK_SYNC_EN
    input  logic             sync_i,
`endif
    output logic             pend_o,
    output logic             clk_o,
    output logic             tick_o
);

    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [CTR_W-1:0] half_q, half_d;
    logic [CTR_W-1:0] pend_half_q, pend_half_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             boundary;
    logic             apply;
    logic             sync_hit;

    always_comb begin
        boundary    = (ctr_q == half_q);
        sync_hit    = 1'b0;
`ifdef GEN_CLK_SYNC_EN
        sync_hit    = sync_i & en_i;
`endif
        ctr_d       = ctr_q;
        clk_d       = clk_q;
        tick_d      = 1'b0;
        half_d      = half_q;
        pend_d      = pend_q;
        pend_half_d = pend_half_q;
        apply       = 1'b0;

        if (sync_hit) begin
            ctr_d  = '0;
            clk_d  = 1'b1;
            tick_d = ~clk_q;
            apply  = 1'b1;
        end else if (!en_i) begin
            ctr_d  = '0;
            clk_d  = 1'b1;
            apply  = 1'b1;
        end else if (boundary) begin
            ctr_d  = '0;
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
            apply  = 1'b1;
        end else begin
            ctr_d  = ctr_q + 1'b1;
        end

        // A write accepted this cycle had pend_q=0, so it can never be applied at this boundary.
        if (apply && pend_q) begin
            half_d = pend_half_q;
            pend_d = 1'b0;
        end
        if (cfg_we_i) begin
            pend_d      = 1'b1;
            pend_half_d = cfg_half_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_q       <= '0;
            half_q      <= CTR_W'(DEF_HALF);
            pend_half_q <= '0;
            pend_q      <= 1'b0;
            clk_q       <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            ctr_q       <= ctr_d;
            half_q      <= half_d;
            pend_half_q <= pend_half_d;
            pend_q      <= pend_d;
            clk_q       <= clk_d;
            tick_q      <= tick_d;
        end
    end

    assign pend_o = pend_q;
    assign clk_o  = clk_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/gen_clk_multi.sv
// NCH-channel programmable clock-enable generator with a shared valid/ready config port.
// Define GEN_CLK_SYNC_EN to add the sync_i phase-alignment input.
module gen_clk_multi
    import gen_clk_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CTR_W    = CTR_W_DEF,
    parameter int unsigned DEF_HALF = DEF_HALF_VAL,
    localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en_i,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CTR_W-1:0] cfg_half,
`ifdef GEN_CLK_SYNC_EN
    input  logic             sync_i,
`endif
    output logic [NCH-1:0]   clk_o,
    output logic [NCH-1:0]   tick_o
);

    logic [NCH-1:0] pend;
    logic [NCH-1:0] cfg_we;

    // Out-of-range channels always look ready so the request completes and is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        if (ch_in_range(32'(cfg_ch), NCH)) begin
            cfg_ready = ~pend[cfg_ch];
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign cfg_we[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));

        gen_clk_chan #(
            .CTR_W    (CTR_W),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en_i       (en_i[i]),
            .cfg_we_i   (cfg_we[i]),
            .cfg_half_i (cfg_half),
`ifdef GEN_CLK_SYNC_EN
            .sync_i     (sync_i),
`endif
            .pend_o     (pend[i]),
            .clk_o      (clk_o[i]),
            .tick_o     (tick_o[i])
        );
    end

endmodule

// File: tb/tb_gen_clk_multi.sv
// Self-checking bench for gen_clk_multi: expected output snapshots are queued per cycle and
// compared on the falling clock edge; config handshake checks are done inline.
module tb_gen_clk_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en_i;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_half;
    logic [3:0]  clk_o;
    logic [3:0]  tick_o;
`ifdef GEN_CLK_SYNC_EN
    logic        sync_i;
`endif

    gen_clk_multi #(
        .NCH      (4),
        .CTR_W    (16),
        .DEF_HALF (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_i),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
`ifdef GEN_CLK_SYNC_EN
        .sync_i    (sync_i),
`endif
        .clk_o     (clk_o),
        .tick_o    (tick_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         at;
        logic [3:0] mask;
        logic [3:0] clk;
        logic [3:0] tick;
    } exp_t;

    typedef struct {
        int         k;
        logic [3:0] mask;
        logic [3:0] clk;
        logic [3:0] tick;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    task automatic chk(input string nm, input int at, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, at, act, exp);
        end
    endtask

    task automatic push(input int at, input logic [3:0] mask, input logic [3:0] c,
                        input logic [3:0] t);
        exp_t e;
        e.at = at; e.mask = mask; e.clk = c; e.tick = t;
        sb.push_back(e);
    endtask

    task automatic add(input int k, input logic [3:0] mask, input logic [3:0] c,
                       input logic [3:0] t);
        vec_t v;
        v.k = k; v.mask = mask; v.clk = c; v.tick = t;
        tbl.push_back(v);
    endtask

    task automatic goto(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                chk("clk_o", cyc, 32'(clk_o & sb[i].mask), 32'(sb[i].clk & sb[i].mask));
                chk("tick_o", cyc, 32'(tick_o & sb[i].mask), 32'(sb[i].tick & sb[i].mask));
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                chk("sb_missed", sb[i].at, 32'(cyc), 32'(sb[i].at));
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    int base;
    int base2;
    int guard;

    initial begin
        // Offsets are edges after reset release; all channels enabled, half=50.
        add(1,   4'hF, 4'hF, 4'h0);
        add(50,  4'hF, 4'hF, 4'h0);
        add(51,  4'hF, 4'h0, 4'h0);
        add(52,  4'hF, 4'h0, 4'h0);
        add(101, 4'hF, 4'h0, 4'h0);
        add(102, 4'hF, 4'hF, 4'hF);
        add(103, 4'hF, 4'hF, 4'h0);
        // ch1 reprogrammed to half=0 at edge 111, takes effect at boundary 153.
        add(140, 4'h2, 4'h2, 4'h0);
        add(152, 4'hF, 4'hF, 4'h0);
        add(153, 4'hF, 4'h0, 4'h0);
        add(154, 4'h2, 4'h2, 4'h2);
        add(155, 4'h2, 4'h0, 4'h0);
        add(156, 4'h2, 4'h2, 4'h2);
        // ch2 half=9 then half=4, ch3 half=7, both first applied at 204.
        add(203, 4'hD, 4'h0, 4'h0);
        add(204, 4'hF, 4'hF, 4'hF);
        add(211, 4'h8, 4'h8, 4'h0);
        add(212, 4'h8, 4'h0, 4'h0);
        add(213, 4'h4, 4'h4, 4'h0);
        add(214, 4'h4, 4'h0, 4'h0);
        add(218, 4'h4, 4'h0, 4'h0);
        add(219, 4'h4, 4'h4, 4'h4);
        add(220, 4'h8, 4'h8, 4'h8);
        add(224, 4'h4, 4'h0, 4'h0);
        // ch0 disabled at 261 while low, re-enabled at 271.
        add(254, 4'h1, 4'h1, 4'h0);
        add(255, 4'h1, 4'h0, 4'h0);
        add(260, 4'h1, 4'h0, 4'h0);
        add(261, 4'h1, 4'h1, 4'h0);
        add(262, 4'h1, 4'h1, 4'h0);
        add(320, 4'h1, 4'h1, 4'h0);
        add(321, 4'h1, 4'h0, 4'h0);

        en_i      = 4'hF;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_half  = 16'd0;
`ifdef GEN_CLK_SYNC_EN
        sync_i    = 1'b0;
`endif
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_clk_o", cyc, 32'(clk_o), 32'hF);
        chk("rst_tick_o", cyc, 32'(tick_o), 32'h0);
        chk("rst_ready", cyc, 32'(cfg_ready), 32'h1);

        @(negedge clk);
        rst  = 1'b0;
        base = cyc;
        foreach (tbl[i]) push(base + tbl[i].k, tbl[i].mask, tbl[i].clk, tbl[i].tick);

        goto(base + 110);
        cfg_ch = 2'd1; cfg_half = 16'd0; cfg_valid = 1'b1;
        #1 chk("cfg1_ready", cyc, 32'(cfg_ready), 32'h1);
        goto(base + 111);
        cfg_valid = 1'b0;
        #1 chk("cfg1_pending", cyc, 32'(cfg_ready), 32'h0);

        goto(base + 160);
        cfg_ch = 2'd2; cfg_half = 16'd9; cfg_valid = 1'b1;
        #1 chk("cfg2a_ready", cyc, 32'(cfg_ready), 32'h1);
        goto(base + 161);
        cfg_half = 16'd4;
        #1 chk("cfg2b_busy", cyc, 32'(cfg_ready), 32'h0);
        cfg_ch = 2'd3; cfg_half = 16'd7;
        #1 chk("cfg3_ready", cyc, 32'(cfg_ready), 32'h1);
        goto(base + 162);
        cfg_ch = 2'd2; cfg_half = 16'd4;
        #1;
        guard = 0;
        while (!cfg_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("cfg2b_free_cyc", cyc, 32'(cyc - base), 32'd204);
        goto(base + 205);
        cfg_valid = 1'b0;

        goto(base + 260);
        en_i[0] = 1'b0;
        goto(base + 270);
        en_i[0] = 1'b1;

        goto(base + 330);
        cfg_ch = 2'd0; cfg_half = 16'd3; cfg_valid = 1'b1;
        #1 chk("cfg0_ready", cyc, 32'(cfg_ready), 32'h1);
        goto(base + 331);
        cfg_valid = 1'b0;
        #1 chk("cfg0_pending", cyc, 32'(cfg_ready), 32'h0);
        goto(base + 335);
        rst = 1'b1;
        #1;
        chk("midrst_clk_o", cyc, 32'(clk_o), 32'hF);
        chk("midrst_tick_o", cyc, 32'(tick_o), 32'h0);
        chk("midrst_ready", cyc, 32'(cfg_ready), 32'h1);
        goto(base + 340);
        rst   = 1'b0;
        base2 = cyc;
        push(base2 + 4,  4'h1, 4'h1, 4'h0);
        push(base2 + 50, 4'hF, 4'hF, 4'h0);
        push(base2 + 51, 4'hF, 4'h0, 4'h0);

`ifdef GEN_CLK_SYNC_EN
        goto(base2 + 60);
        en_i = 4'h0;
        cfg_ch = 2'd0; cfg_half = 16'd3; cfg_valid = 1'b1;
        goto(base2 + 61);
        cfg_ch = 2'd1; cfg_half = 16'd5;
        #1 chk("sync_cfg1_ready", cyc, 32'(cfg_ready), 32'h1);
        goto(base2 + 62);
        cfg_valid = 1'b0;
        push(base2 + 69, 4'h1, 4'h0, 4'h0);
        push(base2 + 71, 4'h2, 4'h0, 4'h0);
        push(base2 + 73, 4'h1, 4'h1, 4'h1);
        push(base2 + 74, 4'h3, 4'h1, 4'h0);
        push(base2 + 75, 4'hF, 4'hF, 4'h2);
        push(base2 + 79, 4'h3, 4'h2, 4'h0);
        push(base2 + 81, 4'h2, 4'h0, 4'h0);
        goto(base2 + 65);
        en_i = 4'h3;
        goto(base2 + 74);
        sync_i = 1'b1;
        goto(base2 + 75);
        sync_i = 1'b0;
`endif

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        chk("sb_drained", cyc, 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
